// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//   PC generation and fetch stage sitting directly in front of a
//   combinational-read instruction memory.  Each fetched word is captured with
//   its PC and a fault code into a small FIFO.  Decode drains that FIFO over a
//   valid/ready handshake.  Misaligned or out-of-range PCs are not fetched.
//   Instead a NOP entry tagged with a fault code is queued, and fetching stops
//   until execute redirects the PC.
//
// Ports
//   clk, rst_n        : clock and synchronous active-low reset
//   imem_addr_o       : byte address to instruction memory (current PC)
//   imem_instr_i      : word returned combinationally for imem_addr_o
//   redirect_valid_i  : execute requests a PC change this cycle
//   redirect_pc_i     : redirect target
//   if_valid_o        : FIFO head holds a valid entry
//   if_ready_i        : decode accepts the head this cycle
//   if_instr_o        : instruction at the FIFO head
//   if_pc_o           : PC of the FIFO head
//   if_fault_o        : 00 none, 01 misaligned, 10 out-of-range
// -----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int unsigned             ADDR_WIDTH = 32,
    parameter int unsigned             DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0]   RESET_PC   = 32'h0000_0000,
    parameter int unsigned             IMEM_SIZE  = 4096,
    parameter int unsigned             FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic [DATA_WIDTH-1:0] imem_instr_i,
    input  logic                  redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0] redirect_pc_i,
    output logic                  if_valid_o,
    input  logic                  if_ready_i,
    output logic [DATA_WIDTH-1:0] if_instr_o,
    output logic [ADDR_WIDTH-1:0] if_pc_o,
    output logic [1:0]            if_fault_o
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_PC = ADDR_WIDTH'(IMEM_SIZE - 4);
    localparam logic [DATA_WIDTH-1:0] NOP     = DATA_WIDTH'(32'h0000_0013);

    localparam logic [1:0] FLT_NONE = 2'b00;
    localparam logic [1:0] FLT_MIS  = 2'b01;
    localparam logic [1:0] FLT_OOR  = 2'b10;

    typedef enum logic {
        ST_RUN,
        ST_FAULT
    } state_t;

    typedef struct packed {
        logic [1:0]            fault;
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } entry_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [PTR_W-1:0]        rd_q, rd_d;
    logic [PTR_W-1:0]        wr_q, wr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    entry_t                  hold_q;
    entry_t                  mem_q [FIFO_DEPTH];

    entry_t                  head;
    entry_t                  push_entry;
    logic                    push;
    logic                    pop;
    logic                    full;

    assign imem_addr_o = pc_q;
    assign if_valid_o  = (count_q != '0);
    assign full        = (count_q == CNT_W'(FIFO_DEPTH));
    assign pop         = if_valid_o & if_ready_i;

    // When empty the head keeps showing whatever was last presented.
    assign head        = if_valid_o ? mem_q[rd_q] : hold_q;
    assign if_instr_o  = head.instr;
    assign if_pc_o     = head.pc;
    assign if_fault_o  = head.fault;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        count_d    = count_q;
        push       = 1'b0;
        push_entry = '{fault: FLT_NONE, pc: pc_q, instr: imem_instr_i};

        if (redirect_valid_i) begin
            // Flush wins over the handshake: a pop this cycle is discarded.
            state_d = ST_RUN;
            pc_d    = redirect_pc_i;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (state_q == ST_RUN && (!full || pop)) begin
                push = 1'b1;
                wr_d = wr_q + PTR_W'(1);
                if (pc_q[1:0] != 2'b00) begin
                    push_entry = '{fault: FLT_MIS, pc: pc_q, instr: NOP};
                    state_d    = ST_FAULT;
                end else if (pc_q > LAST_PC) begin
                    push_entry = '{fault: FLT_OOR, pc: pc_q, instr: NOP};
                    state_d    = ST_FAULT;
                end else begin
                    pc_d = pc_q + ADDR_WIDTH'(4);
                end
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            hold_q  <= head;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    // On a full FIFO with a simultaneous pop, wr_q equals rd_q.  The slot being
    // read out this cycle is the one overwritten at the edge.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem_q[wr_q] <= push_entry;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [1:0]  if_fault;

    logic [31:0] mem [1024];

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model: a transaction queue of {fault, pc, instr} entries
    logic [65:0] q [$];
    logic [31:0] m_pc;
    bit          m_fault_st;
    logic [65:0] m_last;

    always #5 clk = ~clk;

    assign imem_instr = (imem_addr < 32'd4096) ? mem[imem_addr[11:2]] : 32'hDEAD_BEEF;

    instruction_fetch #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .RESET_PC   (32'h0000_0000),
        .IMEM_SIZE  (4096),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_addr_o      (imem_addr),
        .imem_instr_i     (imem_instr),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .if_valid_o       (if_valid),
        .if_ready_i       (if_ready),
        .if_instr_o       (if_instr),
        .if_pc_o          (if_pc),
        .if_fault_o       (if_fault)
    );

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a < 32'd4096) ? mem[a[11:2]] : 32'hDEAD_BEEF;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc       = 32'h0;
        m_fault_st = 1'b0;
        m_last     = '0;
    endtask

    // Apply inputs for one cycle, check outputs against the model, then
    // advance the model and the DUT by one clock edge.
    task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        bit pop, room;
        rst_n          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        if_ready       = rdy;
        #1;
        chk("imem_addr", 66'(imem_addr), 66'(m_pc));
        chk("if_valid", 66'(if_valid), 66'(q.size() != 0));
        if (q.size() != 0) begin
            chk("head", {if_fault, if_pc, if_instr}, q[0]);
            m_last = q[0];
        end else begin
            chk("held_head", {if_fault, if_pc, if_instr}, m_last);
        end

        if (!rst) begin
            model_reset();
        end else if (rv) begin
            q.delete();
            m_pc       = rpc;
            m_fault_st = 1'b0;
        end else begin
            pop  = (q.size() != 0) && rdy;
            room = (q.size() < DEPTH) || pop;
            if (pop) void'(q.pop_front());
            if (!m_fault_st && room) begin
                if (m_pc % 4 != 0) begin
                    q.push_back({2'b01, m_pc, 32'h0000_0013});
                    m_fault_st = 1'b1;
                end else if (m_pc > 32'd4092) begin
                    q.push_back({2'b10, m_pc, 32'h0000_0013});
                    m_fault_st = 1'b1;
                end else begin
                    q.push_back({2'b00, m_pc, mem_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input bit rdy);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        logic [31:0] tgt;
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; if_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();

        // Reset state
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        chk("reset_instr", 66'(if_instr), 66'h0);
        chk("reset_fault", 66'(if_fault), 66'h0);

        // Streaming from reset with decode always ready
        run(6, 1'b1);

        // Backpressure after first valid
        cycle(1'b0, 1'b0, 32'h0, 1'b0);
        run(1, 1'b0);
        run(4, 1'b0);
        chk("stall_pc", 66'(imem_addr), 66'h8);
        run(6, 1'b1);

        // Redirect to 0x40 with FIFO full and decode ready
        run(3, 1'b0);
        cycle(1'b1, 1'b1, 32'h40, 1'b1);
        run(5, 1'b1);

        // Misaligned redirect, stuck, then recovery
        cycle(1'b1, 1'b1, 32'h42, 1'b1);
        run(6, 1'b1);
        chk("stuck_pc", 66'(imem_addr), 66'h42);
        cycle(1'b1, 1'b1, 32'h0, 1'b1);
        run(4, 1'b1);

        // Running off the end of memory
        cycle(1'b1, 1'b1, 32'hFF0, 1'b1);
        run(8, 1'b1);
        chk("oor_pc", 66'(imem_addr), 66'h1000);

        // Reset coinciding with redirect on a full FIFO
        cycle(1'b1, 1'b1, 32'h100, 1'b0);
        run(4, 1'b0);
        cycle(1'b0, 1'b1, 32'h200, 1'b1);
        run(5, 1'b1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                cycle(1'b0, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
            end else if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 9))
                    0:       tgt = 32'($urandom_range(0, 1023)) * 4 + 32'($urandom_range(1, 3));
                    1:       tgt = 32'd4096 + 32'($urandom_range(0, 63)) * 4;
                    2:       tgt = 32'd4092 - 32'($urandom_range(0, 4)) * 4;
                    default: tgt = 32'($urandom_range(0, 1023)) * 4;
                endcase
                cycle(1'b1, 1'b1, tgt, 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'b1, 1'b0, 32'h0, $urandom_range(0, 9) < 7);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
